fp16_widen_arb: RTL and testbench
=================================

# fp16_widen_arb

Two-port arbitrated front end for the half→single widening path. It accepts fp16 operands from two independent requesters over valid/ready and time-shares one combinational fp16→fp32 converter between them. Each result is registered into a single output stage, tagged with its source port, and counted. Sticky exception flags are kept for the FP status register. It sits between the fp16 load/operand buses and the fp32 execution units.

## Interface
- `RR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where port 0 always wins.
- `QUIET_NAN`, default 1: 1 forces frac32[22]=1 on every NaN output; 0 passes the NaN payload through unchanged.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: port 0 has an operand.
- `req0_data` in 16: port 0 fp16 operand.
- `req0_ready` out 1: port 0 operand is accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as port 0, for port 1.
- `out_valid` out 1: the output register holds a result.
- `out_data` out 32: the fp32 result.
- `out_src` out 1: index of the port that supplied the result.
- `out_ready` in 1: the consumer accepts the result this cycle.
- `clr_flags` in 1: synchronous clear of the sticky flags.
- `nan_seen` out 1: sticky; an accepted operand was NaN.
- `denorm_seen` out 1: sticky; an accepted operand was subnormal.
- `conv_count` out 16: number of accepted operands, wrapping.

## Operation
Conversion is fully combinational on the granted operand. Fields: s=in[15], e=in[14:10], f=in[9:0].
- e=0 and f=0: output {s, 31'b0}, i.e. signed zero.
- e=0 and f≠0 (subnormal):
  - p = position of the leading one in f (0..9).
  - exp32 = 103+p.
  - frac32 = f bits below p, left-aligned to bit 22, zero-filled.
- e=31: exp32=FF, frac32={f,13'b0}.
  - If f≠0 and QUIET_NAN=1, frac32[22] is forced to 1.
- Otherwise (normal): exp32 = e+112, frac32={f,13'b0}.
- All conversions are exact; there is no rounding.

Arbitration, combinational:
- Output stage free: `space = !out_valid | out_ready`.
- Grant with one port valid: that port.
- Grant with both valid:
  - RR=1: the port other than `last`.
  - RR=0: port 0.
- `reqN_ready = space & grant==N`.
  - A non-granted port sees ready=0 and must hold its data and valid.
  - `reqN_ready` must not depend on its own `reqN_valid`; it may depend on the other port's valid.
- Transfer: a cycle with `reqN_valid & reqN_ready`. On transfer:
  - out_data ← converted value; out_src ← N; out_valid ← 1.
  - `last` ← N.
  - conv_count ← conv_count+1, wrapping FFFF→0000.
- No transfer and `out_ready`: out_valid ← 0. out_data and out_src hold their values.
- Sticky flags:
  - Set by transfer of a NaN (e=31, f≠0) or a subnormal operand.
  - `clr_flags` clears them.
  - If a flag-setting transfer and `clr_flags` occur in the same cycle, the flag ends at 1.

## Timing
- Latency is 1 cycle: an operand transferred at edge k is visible on out_* after edge k.
- Full throughput: 1 result per cycle while out_ready=1.
- Simultaneous drain and accept in one cycle is required; a bubble there is a bug.
- Output held (out_valid=1, out_ready=0): both readies are 0, and out_data, out_src and out_valid are stable.
- Reset value of every output:
  - out_valid=0, out_data=0, out_src=0.
  - nan_seen=0, denorm_seen=0, conv_count=0.
  - `last`=1, so port 0 wins the first contention.
- Reset asserted mid-operation: any held result is discarded and out_valid drops immediately (asynchronous).
- After rst_n deasserts, the first edge may already accept an operand.

## Test plan
- **Reset:** assert rst_n=0 while out_valid=1 → all outputs read 0 at once; first contention after release grants port 0.
- **Port 0 conversions:** drive 0x3C00, 0x7BFF, 0x8000, 0xFC00 with out_ready=1 → results 0x3F800000, 0x477FE000, 0x80000000, 0xFF800000 on consecutive cycles; conv_count=4.
- **Subnormal and NaN on port 1:**
  - 0x0001 → 0x33800000, and denorm_seen sets.
  - 0x7C01 with QUIET_NAN=1 → 0x7FC02000; with QUIET_NAN=0 → 0x7F802000; nan_seen sets in both cases.
- **Contention:** both ports valid for 4 cycles, RR=1 → out_src sequence 0,1,0,1. With RR=0 → 0,0,0,0, and req1_ready stays 0.
- **Backpressure:** out_ready=0 for 3 cycles with both ports valid → output stable and both readies 0. Then out_ready=1 → drain and the next accept happen in the same cycle, with no lost or duplicated operand.
- **Flag and counter corner cases:**
  - clr_flags asserted in the same cycle as a 0x7E00 transfer → nan_seen=1.
  - clr_flags asserted alone → nan_seen=0.
  - Preload 0xFFFF conversions → conv_count wraps to 0.

Source files
------------

// File: rtl/fp16_widen_arb.sv
// Two-port arbitrated fp16 -> fp32 widening front end. One shared combinational
// converter, a single registered output stage, sticky exception flags and a counter.
module fp16_widen_arb #(
  parameter bit RR        = 1'b1,
  parameter bit QUIET_NAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_src,
  input  logic        out_ready,
  input  logic        clr_flags,
  output logic        nan_seen,
  output logic        denorm_seen,
  output logic [15:0] conv_count
);

  logic        outValid_q, outValid_d;
  logic [31:0] outData_q, outData_d;
  logic        outSrc_q, outSrc_d;
  logic        last_q, last_d;
  logic [15:0] count_q, count_d;
  logic        nanSeen_q, nanSeen_d;
  logic        denSeen_q, denSeen_d;

  logic        space;
  logic        win0, win1;
  logic        xfer0, xfer1, xfer;
  logic        selSrc;
  logic [15:0] selData;

  logic        s;
  logic [4:0]  e;
  logic [9:0]  f;
  logic [3:0]  lead;
  logic [32:0] shifted;
  logic [31:0] convData;
  logic        convNan, convDenorm;

  // Each ready looks only at the other port's valid, so a requester never
  // sees its own valid feed back into its ready.
  assign space      = !outValid_q | out_ready;
  assign win0       = RR ? last_q : 1'b1;
  assign win1       = RR ? !last_q : 1'b0;
  assign req0_ready = space & (!req1_valid | win0);
  assign req1_ready = space & (!req0_valid | win1);

  assign xfer0   = req0_valid & req0_ready;
  assign xfer1   = req1_valid & req1_ready;
  assign xfer    = xfer0 | xfer1;
  assign selSrc  = xfer1;
  assign selData = xfer1 ? req1_data : req0_data;

  assign s = selData[15];
  assign e = selData[14:10];
  assign f = selData[9:0];

  always_comb begin
    convData   = '0;
    lead       = '0;
    shifted    = '0;
    convNan    = (e == 5'h1F) && (f != '0);
    convDenorm = (e == 5'h00) && (f != '0);
    for (int i = 0; i < 10; i++) begin
      if (f[i]) lead = 4'(i);
    end
    if (e == 5'h00 && f == '0) begin
      convData = {s, 31'b0};
    end else if (e == 5'h00) begin
      // Shifting the leading one to bit 23 drops it and left-aligns the rest.
      shifted  = {23'b0, f} << (5'd23 - {1'b0, lead});
      convData = {s, 8'd103 + {4'b0, lead}, shifted[22:0]};
    end else if (e == 5'h1F) begin
      convData = {s, 8'hFF, f, 13'b0};
      if (convNan && QUIET_NAN) convData[22] = 1'b1;
    end else begin
      convData = {s, {3'b0, e} + 8'd112, f, 13'b0};
    end
  end

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSrc_d   = outSrc_q;
    last_d     = last_q;
    count_d    = count_q;
    nanSeen_d  = clr_flags ? 1'b0 : nanSeen_q;
    denSeen_d  = clr_flags ? 1'b0 : denSeen_q;
    if (xfer) begin
      outValid_d = 1'b1;
      outData_d  = convData;
      outSrc_d   = selSrc;
      last_d     = selSrc;
      count_d    = count_q + 16'd1;
      // A flag-setting transfer beats a simultaneous clear.
      if (convNan)    nanSeen_d = 1'b1;
      if (convDenorm) denSeen_d = 1'b1;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSrc_q   <= 1'b0;
      last_q     <= 1'b1;
      count_q    <= '0;
      nanSeen_q  <= 1'b0;
      denSeen_q  <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSrc_q   <= outSrc_d;
      last_q     <= last_d;
      count_q    <= count_d;
      nanSeen_q  <= nanSeen_d;
      denSeen_q  <= denSeen_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_data    = outData_q;
  assign out_src     = outSrc_q;
  assign conv_count  = count_q;
  assign nan_seen    = nanSeen_q;
  assign denorm_seen = denSeen_q;

endmodule

// File: tb/tb_fp16_widen_arb.sv
// Bench for fp16_widen_arb: instance A (RR=1, QUIET_NAN=1) and instance B
// (RR=0, QUIET_NAN=0), each with its own requesters, checked against a reference model.
module tb_fp16_widen_arb;

  logic clk;
  logic rst_n;

  logic [1:0]       v0, v1, r0, r1, oRdy, clr, oV, oS, nanS, denS;
  logic [1:0][15:0] d0, d1, cnt;
  logic [1:0][31:0] oD;

  int total;
  int bad;

  typedef struct {
    logic        outValid;
    logic [31:0] outData;
    logic        outSrc;
    logic        last;
    logic [15:0] count;
    logic        nanSeen;
    logic        denSeen;
  } model_t;

  typedef struct {
    logic        port;
    logic [15:0] din;
    logic [31:0] expA;
    logic [31:0] expB;
  } vec_t;

  model_t m[2];
  int     lastXfer[2];
  vec_t   vecs[9];
  logic   hold0[2];
  logic   hold1[2];

  fp16_widen_arb #(.RR(1'b1), .QUIET_NAN(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1[0]),
    .out_valid(oV[0]), .out_data(oD[0]), .out_src(oS[0]), .out_ready(oRdy[0]),
    .clr_flags(clr[0]), .nan_seen(nanS[0]), .denorm_seen(denS[0]), .conv_count(cnt[0])
  );

  fp16_widen_arb #(.RR(1'b0), .QUIET_NAN(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1[1]),
    .out_valid(oV[1]), .out_data(oD[1]), .out_src(oS[1]), .out_ready(oRdy[1]),
    .clr_flags(clr[1]), .nan_seen(nanS[1]), .denorm_seen(denS[1]), .conv_count(cnt[1])
  );

  always #5 clk = ~clk;

  function automatic string instName(input int k);
    return (k == 0) ? "A" : "B";
  endfunction

  // Value-level fp16 -> fp32 reference: exponent/fraction derived arithmetically.
  function automatic logic [31:0] refConvert(input logic [15:0] h, input bit qn);
    int e;
    int f;
    int p;
    int frac;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0 && f == 0) return {h[15], 31'b0};
    if (e == 0) begin
      p = 0;
      while ((f >> (p + 1)) != 0) p++;
      frac = (f - (1 << p)) * (1 << (23 - p));
      return {h[15], 8'(103 + p), 23'(frac)};
    end
    if (e == 31) begin
      frac = f * 8192;
      if (qn && f != 0) frac = frac | (1 << 22);
      return {h[15], 8'hFF, 23'(frac)};
    end
    return {h[15], 8'(e + 112), 23'(f * 8192)};
  endfunction

  function automatic logic [15:0] randHalf();
    logic [31:0] r;
    r = $urandom;
    case (r[18:16])
      3'd0:    return {r[15], 5'd0, r[9:0]};
      3'd1:    return {r[15], 5'h1F, r[9:0]};
      3'd2:    return {r[15], 15'd0};
      3'd3:    return {r[15], 5'h1F, 10'd0};
      default: return r[15:0];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      m[k].outValid = 1'b0;
      m[k].outData  = '0;
      m[k].outSrc   = 1'b0;
      m[k].last     = 1'b1;
      m[k].count    = '0;
      m[k].nanSeen  = 1'b0;
      m[k].denSeen  = 1'b0;
      lastXfer[k]   = -1;
    end
  endtask

  // Compare current DUT state/readies with the model, then advance the model by one edge.
  task automatic stepModel(input int k);
    logic        space;
    int          grant;
    int          x;
    logic [15:0] d;
    string       n;
    n = instName(k);
    space = !m[k].outValid || oRdy[k];
    if (v0[k] && v1[k]) grant = (k == 0) ? (m[k].last ? 0 : 1) : 0;
    else if (v1[k])     grant = 1;
    else                grant = 0;
    if (v0[k]) checkOutput({n, ".req0_ready"}, 32'(r0[k]), 32'(space && grant == 0));
    if (v1[k]) checkOutput({n, ".req1_ready"}, 32'(r1[k]), 32'(space && grant == 1));
    checkOutput({n, ".out_valid"}, 32'(oV[k]), 32'(m[k].outValid));
    checkOutput({n, ".out_data"}, oD[k], m[k].outData);
    checkOutput({n, ".out_src"}, 32'(oS[k]), 32'(m[k].outSrc));
    checkOutput({n, ".conv_count"}, 32'(cnt[k]), 32'(m[k].count));
    checkOutput({n, ".nan_seen"}, 32'(nanS[k]), 32'(m[k].nanSeen));
    checkOutput({n, ".denorm_seen"}, 32'(denS[k]), 32'(m[k].denSeen));
    x = -1;
    if (space && v0[k] && grant == 0)      x = 0;
    else if (space && v1[k] && grant == 1) x = 1;
    lastXfer[k] = x;
    if (clr[k]) begin
      m[k].nanSeen = 1'b0;
      m[k].denSeen = 1'b0;
    end
    if (x >= 0) begin
      d = (x == 1) ? d1[k] : d0[k];
      m[k].outValid = 1'b1;
      m[k].outData  = refConvert(d, k == 0);
      m[k].outSrc   = (x == 1);
      m[k].last     = (x == 1);
      m[k].count    = m[k].count + 16'd1;
      if (d[14:10] == 5'h1F && d[9:0] != 0) m[k].nanSeen = 1'b1;
      if (d[14:10] == 5'h00 && d[9:0] != 0) m[k].denSeen = 1'b1;
    end else if (oRdy[k]) begin
      m[k].outValid = 1'b0;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic applyStimulus();
    #1;
    for (int k = 0; k < 2; k++) stepModel(k);
    @(negedge clk);
  endtask

  task automatic drive(input logic a0, input logic [15:0] x0, input logic a1,
                       input logic [15:0] x1, input logic rdy, input logic c);
    for (int k = 0; k < 2; k++) begin
      v0[k] = a0; d0[k] = x0; v1[k] = a1; d1[k] = x1; oRdy[k] = rdy; clr[k] = c;
    end
  endtask

  task automatic checkResetState(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, ".", instName(k), ".out_valid"}, 32'(oV[k]), 32'd0);
      checkOutput({tag, ".", instName(k), ".out_data"}, oD[k], 32'd0);
      checkOutput({tag, ".", instName(k), ".out_src"}, 32'(oS[k]), 32'd0);
      checkOutput({tag, ".", instName(k), ".conv_count"}, 32'(cnt[k]), 32'd0);
      checkOutput({tag, ".", instName(k), ".nan_seen"}, 32'(nanS[k]), 32'd0);
      checkOutput({tag, ".", instName(k), ".denorm_seen"}, 32'(denS[k]), 32'd0);
    end
  endtask

  initial begin
    int it;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    drive(0, 16'h0, 0, 16'h0, 0, 0);
    resetModel();

    vecs[0] = '{1'b0, 16'h3C00, 32'h3F800000, 32'h3F800000};
    vecs[1] = '{1'b0, 16'h7BFF, 32'h477FE000, 32'h477FE000};
    vecs[2] = '{1'b0, 16'h8000, 32'h80000000, 32'h80000000};
    vecs[3] = '{1'b0, 16'hFC00, 32'hFF800000, 32'hFF800000};
    vecs[4] = '{1'b1, 16'h0001, 32'h33800000, 32'h33800000};
    vecs[5] = '{1'b1, 16'h7C01, 32'h7FC02000, 32'h7F802000};
    vecs[6] = '{1'b1, 16'h03FF, 32'h387FC000, 32'h387FC000};
    vecs[7] = '{1'b0, 16'h0400, 32'h38800000, 32'h38800000};
    vecs[8] = '{1'b1, 16'h7C00, 32'h7F800000, 32'h7F800000};

    repeat (2) @(negedge clk);
    #1 checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(!vecs[i].port, vecs[i].din, vecs[i].port, vecs[i].din, 1, 0);
      applyStimulus();
      checkOutput($sformatf("vec%0d.A.data", i), oD[0], vecs[i].expA);
      checkOutput($sformatf("vec%0d.B.data", i), oD[1], vecs[i].expB);
      checkOutput($sformatf("vec%0d.A.src", i), 32'(oS[0]), 32'(vecs[i].port));
      checkOutput($sformatf("vec%0d.B.src", i), 32'(oS[1]), 32'(vecs[i].port));
      if (i == 3) begin
        checkOutput("port0.A.count", 32'(cnt[0]), 32'd4);
        checkOutput("port0.B.count", 32'(cnt[1]), 32'd4);
      end
    end
    checkOutput("vec.A.nan", 32'(nanS[0]), 32'd1);
    checkOutput("vec.B.nan", 32'(nanS[1]), 32'd1);
    checkOutput("vec.A.denorm", 32'(denS[0]), 32'd1);
    checkOutput("vec.B.denorm", 32'(denS[1]), 32'd1);

    // Contention: A alternates starting at port 0, B always serves port 0.
    drive(1, 16'h3C00, 1, 16'h4000, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("contend%0d.A.src", i), 32'(oS[0]), 32'(i % 2));
      checkOutput($sformatf("contend%0d.B.src", i), 32'(oS[1]), 32'd0);
      checkOutput($sformatf("contend%0d.B.req1_ready", i), 32'(r1[1]), 32'd0);
    end

    // Backpressure: output frozen, both readies low.
    drive(1, 16'h3C00, 1, 16'h4000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("hold%0d.A.data", i), oD[0], 32'h40000000);
      checkOutput($sformatf("hold%0d.A.src", i), 32'(oS[0]), 32'd1);
      checkOutput($sformatf("hold%0d.B.data", i), oD[1], 32'h3F800000);
      checkOutput($sformatf("hold%0d.A.valid", i), 32'(oV[0]), 32'd1);
      checkOutput($sformatf("hold%0d.A.readies", i), 32'({r0[0], r1[0]}), 32'd0);
      checkOutput($sformatf("hold%0d.B.readies", i), 32'({r0[1], r1[1]}), 32'd0);
    end
    drive(1, 16'h3C00, 1, 16'h4000, 1, 0);
    applyStimulus();
    checkOutput("drain.A.valid", 32'(oV[0]), 32'd1);
    checkOutput("drain.A.src", 32'(oS[0]), 32'd0);
    checkOutput("drain.A.data", oD[0], 32'h3F800000);
    checkOutput("drain.A.count", 32'(cnt[0]), 32'd14);
    checkOutput("drain.B.count", 32'(cnt[1]), 32'd14);

    // Flag set and clear in the same cycle: set wins.
    drive(1, 16'h7E00, 0, 16'h0, 1, 1);
    applyStimulus();
    checkOutput("clrset.A.nan", 32'(nanS[0]), 32'd1);
    checkOutput("clrset.B.nan", 32'(nanS[1]), 32'd1);
    checkOutput("clrset.A.data", oD[0], 32'h7FC00000);
    checkOutput("clrset.B.data", oD[1], 32'h7FC00000);
    drive(0, 16'h0, 0, 16'h0, 1, 1);
    applyStimulus();
    checkOutput("clr.A.nan", 32'(nanS[0]), 32'd0);
    checkOutput("clr.B.nan", 32'(nanS[1]), 32'd0);
    checkOutput("clr.A.denorm", 32'(denS[0]), 32'd0);

    // Asynchronous reset while a result is held.
    drive(1, 16'h3C00, 0, 16'h0, 0, 0);
    applyStimulus();
    checkOutput("prereset.A.valid", 32'(oV[0]), 32'd1);
    checkOutput("prereset.B.valid", 32'(oV[1]), 32'd1);
    rst_n = 1'b0;
    drive(0, 16'h0, 0, 16'h0, 0, 0);
    #1 checkResetState("midreset");
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'h3C00, 1, 16'h4000, 1, 0);
    applyStimulus();
    checkOutput("postreset.A.src", 32'(oS[0]), 32'd0);
    checkOutput("postreset.B.src", 32'(oS[1]), 32'd0);
    checkOutput("postreset.A.data", oD[0], 32'h3F800000);
    checkOutput("postreset.A.count", 32'(cnt[0]), 32'd1);

    // Randomized traffic; a stalled requester holds its valid and data.
    for (int k = 0; k < 2; k++) begin
      hold0[k] = 1'b0;
      hold1[k] = 1'b0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold0[k]) begin
          v0[k] = ($urandom_range(0, 3) != 0);
          d0[k] = randHalf();
        end
        if (!hold1[k]) begin
          v1[k] = ($urandom_range(0, 3) != 0);
          d1[k] = randHalf();
        end
        oRdy[k] = ($urandom_range(0, 3) != 0);
        clr[k]  = ($urandom_range(0, 15) == 0);
      end
      applyStimulus();
      for (int k = 0; k < 2; k++) begin
        hold0[k] = v0[k] && (lastXfer[k] != 0);
        hold1[k] = v1[k] && (lastXfer[k] != 1);
      end
    end

    // Counter wrap: run each instance up to FFFF, then one more transfer.
    it = 0;
    while ((m[0].count != 16'hFFFF || m[1].count != 16'hFFFF) && it < 70000) begin
      for (int k = 0; k < 2; k++) begin
        v0[k] = (m[k].count != 16'hFFFF);
        d0[k] = 16'h3C00;
        v1[k] = 1'b0;
        oRdy[k] = 1'b1;
        clr[k]  = 1'b0;
      end
      applyStimulus();
      it++;
    end
    checkOutput("wrap.A.countFFFF", 32'(cnt[0]), 32'h0000FFFF);
    checkOutput("wrap.B.countFFFF", 32'(cnt[1]), 32'h0000FFFF);
    drive(1, 16'h3C00, 0, 16'h0, 1, 0);
    applyStimulus();
    checkOutput("wrap.A.count0", 32'(cnt[0]), 32'd0);
    checkOutput("wrap.B.count0", 32'(cnt[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
